// File: rtl/i2s_pkg.sv
// Shared types and default sizes for the I2S capture controller.
package i2s_pkg;
  localparam int DATA_SIZE_DEF = 24;
  localparam int COUNT_W_DEF   = 16;
  localparam int SKIP_W_DEF    = 8;
  localparam int OVF_CNT_W     = 8;

  typedef enum logic [1:0] {IDLE, SKIP, CAPTURE, DRAIN} cap_state_t;
endpackage

// File: rtl/i2s_capture_ctrl_if.sv
// Valid/ready sample stream from the capture controller to the downstream sink.
interface i2s_capture_ctrl_if #(parameter int DATA_SIZE = i2s_pkg::DATA_SIZE_DEF);
  logic                 m_valid;
  logic [DATA_SIZE-1:0] m_data;
  logic                 m_ready;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/i2s_sample_hold.sv
// One-entry valid/ready holding register; a load into a stalled entry is reported as a drop.
module i2s_sample_hold
  import i2s_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 load,
  input  logic [DATA_SIZE-1:0] load_data,
  output logic                 accept,
  output logic                 drop,
  i2s_capture_ctrl_if.master   m
);

  logic hshk;

  assign hshk   = m.m_valid & m.m_ready;
  // a handshake in the same cycle frees the entry for the incoming sample
  assign accept = load & (~m.m_valid | m.m_ready);
  assign drop   = load & m.m_valid & ~m.m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m.m_valid <= 1'b0;
      m.m_data  <= '0;
    end else if (clear) begin
      m.m_valid <= 1'b0;
    end else if (accept) begin
      m.m_valid <= 1'b1;
      m.m_data  <= load_data;
    end else if (hshk) begin
      m.m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/i2s_capture_ctrl.sv
// Capture session sequencer for one I2S receiver: reset hold, warm-up skip, counted capture, drain.
// Optional saturating drop counter output ovf_count when I2S_CAPTURE_OVF_CNT_EN is defined.
module i2s_capture_ctrl
  import i2s_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int COUNT_W   = COUNT_W_DEF,
  parameter int SKIP_W    = SKIP_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [COUNT_W-1:0]   cfg_count,
  input  logic [SKIP_W-1:0]    cfg_skip,
  output logic                 rx_rst_n,
  input  logic                 rx_ready,
  input  logic [DATA_SIZE-1:0] rx_data,
  i2s_capture_ctrl_if.master   m,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [COUNT_W-1:0]   sample_idx
`ifdef I2S_CAPTURE_OVF_CNT_EN
  ,
  output logic [OVF_CNT_W-1:0] ovf_count
`endif
);

  cap_state_t         state;
  logic               rx_ready_q;
  logic [SKIP_W-1:0]  skip_cnt;
  logic [COUNT_W-1:0] count_lat;
  logic               sample_evt;
  logic               abort_act;
  logic               start_sess;
  logic               load;
  logic               accept;
  logic               drop;

  assign sample_evt = rx_ready & ~rx_ready_q;
  assign abort_act  = abort & (state != IDLE);
  assign start_sess = start & ~abort & (state == IDLE);
  assign load       = sample_evt & (state == CAPTURE) & ~abort;

  i2s_sample_hold #(.DATA_SIZE(DATA_SIZE)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .clear     (abort_act),
    .load      (load),
    .load_data (rx_data),
    .accept    (accept),
    .drop      (drop),
    .m         (m)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rx_rst_n   <= 1'b0;
      rx_ready_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      sample_idx <= '0;
      skip_cnt   <= '0;
      count_lat  <= '0;
    end else begin
      // edge detector is held clear while the receiver is in reset
      rx_ready_q <= rx_rst_n & rx_ready;
      done       <= 1'b0;
      if (accept) sample_idx <= sample_idx + COUNT_W'(1);
      if (drop)   overflow   <= 1'b1;
      if (abort_act) begin
        state    <= IDLE;
        rx_rst_n <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_sess) begin
              count_lat  <= cfg_count;
              skip_cnt   <= cfg_skip;
              overflow   <= 1'b0;
              sample_idx <= '0;
              rx_rst_n   <= 1'b1;
              busy       <= 1'b1;
              state      <= (cfg_skip == '0) ? CAPTURE : SKIP;
            end
          end
          SKIP: begin
            if (sample_evt) begin
              skip_cnt <= skip_cnt - SKIP_W'(1);
              if (skip_cnt == SKIP_W'(1)) state <= CAPTURE;
            end
          end
          CAPTURE: begin
            if (accept && (count_lat != '0) && (sample_idx + COUNT_W'(1) == count_lat)) begin
              rx_rst_n <= 1'b0;
              state    <= DRAIN;
            end
          end
          DRAIN: begin
            if (!m.m_valid || m.m_ready) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef I2S_CAPTURE_OVF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_count <= '0;
    end else if (start_sess) begin
      ovf_count <= '0;
    end else if (drop && (ovf_count != {OVF_CNT_W{1'b1}})) begin
      ovf_count <= ovf_count + OVF_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_i2s_capture_ctrl.sv
// Scoreboard bench for i2s_capture_ctrl: random receiver/sink timing against a session-level model.
module tb_i2s_capture_ctrl;
  localparam int DW = 24;
  localparam int CW = 16;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] cfg_count = '0;
  logic [SW-1:0] cfg_skip = '0;
  logic          rx_rst_n;
  logic          rx_ready = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          busy, done, overflow;
  logic [CW-1:0] sample_idx;
`ifdef I2S_CAPTURE_OVF_CNT_EN
  logic [7:0]    ovf_count;
`endif

  i2s_capture_ctrl_if #(.DATA_SIZE(DW)) m_if ();

  i2s_capture_ctrl #(.DATA_SIZE(DW), .COUNT_W(CW), .SKIP_W(SW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .cfg_count  (cfg_count),
    .cfg_skip   (cfg_skip),
    .rx_rst_n   (rx_rst_n),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .m          (m_if),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .sample_idx (sample_idx)
`ifdef I2S_CAPTURE_OVF_CNT_EN
    ,
    .ovf_count  (ovf_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model: session view after the most recent clock edge
  bit s_act, s_drain, s_slot, s_ovf, s_done;
  int s_seen, s_skip, s_count, s_idx, s_ovfc;
  logic [DW-1:0] expq[$];
  int rx_timer = 3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    s_act = 0; s_drain = 0; s_slot = 0; s_ovf = 0; s_done = 0;
    s_seen = 0; s_skip = 0; s_count = 0; s_idx = 0; s_ovfc = 0;
    expq.delete();
  endtask

  task automatic chk_reset_values();
    chk("rst_rx_rst_n", rx_rst_n, 0);
    chk("rst_m_valid", m_if.m_valid, 0);
    chk("rst_m_data", m_if.m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_sample_idx", sample_idx, 0);
`ifdef I2S_CAPTURE_OVF_CNT_EN
    chk("rst_ovf_count", ovf_count, 0);
`endif
  endtask

  // monitor: every handshake pops the oldest expected sample
  always @(negedge clk) begin
    if (!rst && m_if.m_valid && m_if.m_ready) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL hs_extra actual=%0h required=no_sample", m_if.m_data);
      end else begin
        chk("hs_data", m_if.m_data, expq.pop_front());
      end
    end
  end

  task automatic check_state();
    chk("busy", busy, s_act);
    chk("rx_rst_n", rx_rst_n, s_act && !s_drain);
    chk("done", done, s_done);
    chk("m_valid", m_if.m_valid, s_slot);
    chk("overflow", overflow, s_ovf);
    chk("sample_idx", sample_idx, s_idx);
    if (s_slot && expq.size() > 0) chk("m_data_hold", m_if.m_data, expq[0]);
`ifdef I2S_CAPTURE_OVF_CNT_EN
    chk("ovf_count", ovf_count, s_ovfc);
`endif
  endtask

  // called 2ns after each rising edge: check, drive next inputs, advance model to the next edge
  task automatic tick(input bit do_start, input bit do_abort, input int rmode, input bit stall);
    bit rise;
    bit ld;
    rise = 0;
    ld = 0;
    check_state();
    if (!rx_rst_n) begin
      rx_ready = 1'b0;
      rx_timer = $urandom_range(2, 4);
    end else if (rx_ready) begin
      rx_ready = 1'b0;
    end else if (rx_timer == 0) begin
      rx_ready = 1'b1;
      rx_data  = DW'($urandom);
      rise     = 1;
      rx_timer = $urandom_range(2, 5);
    end else begin
      rx_timer--;
    end
    if (stall)           m_if.m_ready = 1'b0;
    else if (rmode == 0) m_if.m_ready = 1'b1;
    else if (rmode == 1) m_if.m_ready = 1'($urandom_range(0, 1));
    else                 m_if.m_ready = rise | s_drain;
    start = do_start;
    abort = do_abort;
    s_done = 0;
    if (!s_act) begin
      if (do_start && !do_abort) begin
        s_act = 1; s_drain = 0; s_seen = 0; s_idx = 0; s_ovf = 0; s_ovfc = 0;
        s_skip = int'(cfg_skip); s_count = int'(cfg_count);
      end
    end else if (do_abort) begin
      if (s_slot && !m_if.m_ready) void'(expq.pop_back());
      s_act = 0; s_drain = 0; s_slot = 0;
    end else if (s_drain) begin
      if (!s_slot || m_if.m_ready) begin
        s_slot = 0; s_act = 0; s_drain = 0; s_done = 1;
      end
    end else begin
      if (rise) begin
        s_seen++;
        if (s_seen > s_skip) begin
          if (s_slot && !m_if.m_ready) begin
            s_ovf = 1;
            if (s_ovfc < 255) s_ovfc++;
          end else begin
            expq.push_back(rx_data);
            s_idx = (s_idx + 1) % 65536;
            ld = 1;
          end
        end
      end
      if (ld) s_slot = 1;
      else if (s_slot && m_if.m_ready) s_slot = 0;
      if (ld && s_count != 0 && s_idx == s_count) s_drain = 1;
    end
  endtask

  task automatic run_session(input int skip, input int count, input int rmode,
                             input int stall_cyc, input int abort_idx, input int max_cyc);
    int n;
    cfg_skip  = SW'(skip);
    cfg_count = CW'(count);
    @(posedge clk); #2;
    tick(1, 0, rmode, stall_cyc > 0);
    n = 1;
    while (s_act && n < max_cyc) begin
      @(posedge clk); #2;
      tick(0, (abort_idx != 0) && (s_idx >= abort_idx) && (n >= stall_cyc), rmode, n < stall_cyc);
      n++;
    end
    chk("session_in_budget", n < max_cyc, 1);
    repeat (3) begin
      @(posedge clk); #2;
      tick(0, 0, rmode, 0);
    end
    chk("queue_drained", expq.size(), 0);
  endtask

  initial begin
    int n;
    model_reset();
    m_if.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk_reset_values();
    @(negedge clk) rst = 1'b0;

    run_session(2, 3, 0, 0, 0, 400);   // warm-up skip then counted capture
    run_session(0, 4, 0, 40, 0, 400);  // stalled sink: drops, first sample held
    run_session(0, 0, 0, 0, 10, 400);  // continuous, aborted after 10 samples
    run_session(0, 5, 2, 0, 0, 400);   // handshake coincides with each new sample

    // asynchronous reset in the middle of a capture
    cfg_skip = 1; cfg_count = 0;
    @(posedge clk); #2;
    tick(1, 0, 0, 0);
    n = 0;
    while (s_idx < 3 && n < 200) begin
      @(posedge clk); #2;
      tick(0, 0, 0, 0);
      n++;
    end
    chk("async_setup_in_budget", n < 200, 1);
    #2 rst = 1'b1;
    #1;
    chk_reset_values();
    model_reset();
    rx_ready = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    run_session(1, 3, 0, 0, 0, 400);

    for (int i = 0; i < 5; i++)
      run_session($urandom_range(0, 3), $urandom_range(1, 8), 1, $urandom_range(0, 12), 0, 800);

`ifdef I2S_CAPTURE_OVF_CNT_EN
    run_session(0, 0, 0, 1500, 2, 3000);  // >256 drops: counter saturates
    chk("ovf_count_saturated", ovf_count, 255);
    run_session(0, 2, 0, 0, 0, 400);      // start clears the counter
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2s_capture_ctrl.md
Name: i2s_capture_ctrl

Overview:
Sequences one I2S microphone receiver through a capture session: holds the receiver in reset while idle, releases it on start, discards warm-up samples, then forwards a programmed number of samples to a downstream valid/ready sink. Sits between receiver_i2s and the sample FIFO/readout path. Owns the session state, the one-entry output holding register and overflow detection.

Parameters:
DATA_SIZE, 24, sample width; must match the receiver's DATA_SIZE.
COUNT_W, 16, width of the sample-count configuration and index.
SKIP_W, 8, width of the warm-up discard count.

Ports:
clk  in  1  system clock, shared with the receiver
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; begins a session when IDLE
abort  in  1  one-cycle pulse; ends the session from any state
cfg_count  in  COUNT_W  samples to deliver; 0 = continuous until abort
cfg_skip  in  SKIP_W  samples discarded after receiver release
rx_rst_n  out  1  drives the receiver's rst_n; 0 holds the receiver in reset
rx_ready  in  1  receiver ready (level); the rising edge marks a new sample
rx_data  in  DATA_SIZE  receiver audio_data
m_valid  out  1  output sample valid
m_data  out  DATA_SIZE  output sample
m_ready  in  1  sink accepts when m_valid && m_ready
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on normal completion; not asserted on abort
overflow  out  1  sticky; cleared on start
sample_idx  out  COUNT_W  samples accepted into the holding register this session

Behaviour:
- Reset values: state IDLE, rx_rst_n=0, m_valid=0, m_data=0, busy=0, done=0, overflow=0, sample_idx=0, skip counter=0, edge-detect register=0.
- Sample event: a single-cycle internal strobe sample_evt = rx_ready & ~rx_ready_q, where rx_ready_q is registered every cycle. rx_ready_q is forced to 0 while rx_rst_n=0.
- States and transitions:
  - IDLE: rx_rst_n=0. On start, latch cfg_count and cfg_skip and clear overflow and sample_idx. If the latched skip is 0, go to CAPTURE; otherwise go to SKIP.
  - SKIP: rx_rst_n=1. Each sample_evt decrements the skip counter. When it reaches 0, go to CAPTURE on the following cycle. Skipped data is never presented on m_data.
  - CAPTURE: rx_rst_n=1. On sample_evt, rx_data is loaded into m_data, m_valid is set and sample_idx is incremented.
    - Holding register full (m_valid=1 and no handshake this cycle) when sample_evt arrives: drop the new sample, set overflow, leave m_data unchanged and do not increment sample_idx.
    - Handshake and sample_evt in the same cycle: load the new sample; m_valid stays 1.
    - When sample_idx reaches the latched count (count ≠ 0), stop loading and go to DRAIN.
  - DRAIN: rx_rst_n=0. Wait for the final handshake (or go straight on if m_valid=0), pulse done for one cycle and go to IDLE.
- Abort, any non-IDLE state: next cycle go to IDLE with rx_rst_n=0 and m_valid=0. A pending sample is discarded and done is not pulsed.
- Abort and start in the same cycle: abort wins. start outside IDLE is ignored.
- Count wrap: in continuous mode sample_idx wraps from 2^COUNT_W-1 to 0 without any event.
- Latency: sample_evt at cycle N gives m_valid=1 with the new m_data at N+1. rx_ready rising at cycle N gives sample_evt at N, so the output is registered one cycle after the receiver's ready edge.
- m_data holds its value while m_valid=1 and m_ready=0 (standard valid/ready stability rule).

Optional Feature:
Macro I2S_CAPTURE_OVF_CNT_EN.
- Defined: adds output ovf_count (8 bits). It increments on each dropped sample, saturates at 255 and clears on start.
- Not defined: the port and counter do not exist; only the sticky overflow flag is provided.

Decomposition:
- Package i2s_pkg: state enum cap_state_t {IDLE, SKIP, CAPTURE, DRAIN}; localparam defaults for DATA_SIZE and COUNT_W.
- Sub-module i2s_sample_hold: the one-entry valid/ready holding register, with load/overflow inputs and outputs. The FSM stays in the top module.

Test Plan:
- Start with cfg_skip=2, cfg_count=3, m_ready=1 → first 2 receiver samples absent from the output; next 3 delivered in order; done pulses once; rx_rst_n returns to 0; sample_idx=3.
- cfg_skip=0, cfg_count=4, m_ready held 0 after the first sample → overflow=1, the first sample held stable on m_data, sample_idx=1. Release m_ready → that sample handshakes.
- cfg_count=0, abort after 10 samples → 10 handshakes, no done pulse, m_valid=0 and rx_rst_n=0 the cycle after abort.
- Handshake coinciding with sample_evt → no overflow, new data present on the next cycle, sample_idx incremented.
- Assert rst mid-CAPTURE, asynchronously between clock edges → all outputs take their reset values immediately. A later start works normally.
- With I2S_CAPTURE_OVF_CNT_EN defined and m_ready=0 across 300 samples → ovf_count saturates at 255; the next start clears it to 0.
